sar_search8: RTL and testbench

Successive-approximation search engine, the driving end of the 8-bit magnitude comparator. It presents trial codes on `trial`, consumes the comparator's greater/less/equal verdict against an external target, and resolves the target one bit per step, MSB first. It sits beside the comparator in ADC-style and threshold-finding datapaths, and exits early on an equal verdict.

---
 rtl/sar_pkg.sv | 32 +++
 rtl/sar_settle_timer.sv | 29 ++
 rtl/sar_search8.sv | 126 ++++++++++++
 tb/tb_sar_search8.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine:
// FSM states, settle-counter width and comparator verdict decoding.
package sar_pkg;

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } sarState_t;

    typedef enum logic [1:0] {
        V_GT  = 2'd0,
        V_LT  = 2'd1,
        V_EQ  = 2'd2,
        V_BAD = 2'd3
    } verdict_t;

    // Anything other than exactly one asserted flag is an illegal verdict.
    function automatic verdict_t decodeVerdict(input logic gt, input logic lt, input logic eq);
        verdict_t v;
        case ({gt, lt, eq})
            3'b100:  v = V_GT;
            3'b010:  v = V_LT;
            3'b001:  v = V_EQ;
            default: v = V_BAD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable down-counter: holds each trial for loadValue+1 cycles and flags
// the cycle on which the comparator verdict is to be sampled.
module sar_settle_timer
    import sar_pkg::*;
#(
    parameter int unsigned W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    output logic         sample
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign sample = (count == '0);

endmodule

// File: rtl/sar_search8.sv
// Successive-approximation search: presents trial codes MSB first, consumes
// gt/lt/eq verdicts and resolves the target, exiting early on equality.
module sar_search8
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sarState_t        state, stateNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0] resultNext;
    logic             exactNext, errNext;
    logic [WIDTH-1:0] trialCode;
    logic             timerLoad;
    logic             sample;
    verdict_t         verdict;

    sar_settle_timer #(.W(SETTLE_W)) uTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timerLoad),
        .loadValue (SETTLE_W'(SETTLE)),
        .sample    (sample)
    );

    // acc holds the bits already resolved; the bit under test rides on top.
    assign trialCode = acc | (WIDTH'(1) << idx);
    assign verdict   = decodeVerdict(cmp_gt, cmp_lt, cmp_eq);

    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        accNext    = acc;
        resultNext = result;
        exactNext  = exact;
        errNext    = err;
        timerLoad  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext  = TRY;
                    idxNext    = IDX_W'(WIDTH - 1);
                    accNext    = '0;
                    resultNext = '0;
                    exactNext  = 1'b0;
                    errNext    = 1'b0;
                    timerLoad  = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end

            TRY: begin
                if (sample) begin
                    case (verdict)
                        V_EQ: begin
                            stateNext  = DONE;
                            resultNext = trialCode;
                            exactNext  = 1'b1;
                        end
                        V_BAD: begin
                            stateNext  = DONE;
                            resultNext = '0;
                            errNext    = 1'b1;
                        end
                        default: begin
                            if (verdict == V_LT) begin
                                accNext = trialCode;
                            end
                            if (idx == '0) begin
                                stateNext  = DONE;
                                resultNext = accNext;
                            end else begin
                                idxNext   = idx - IDX_W'(1);
                                timerLoad = 1'b1;
                            end
                        end
                    endcase
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
            exact  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= stateNext;
            idx    <= idxNext;
            acc    <= accNext;
            result <= resultNext;
            exact  <= exactNext;
            err    <= errNext;
        end
    end

    assign trial = (state == TRY) ? trialCode : '0;
    assign busy  = (state == TRY);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_sar_search8.sv
// Bench for sar_search8: two instances (SETTLE 0 and 3) driven by a target-based
// comparator, checked every cycle against a search-level behavioural model.
module tb_sar_search8;

    localparam int SETTLE_A = 0;
    localparam int SETTLE_B = 3;

    typedef struct packed {
        logic [7:0][7:0] tr;
        logic [3:0]      len;
        logic [7:0]      res;
        logic            ex;
        logic            er;
    } plan_t;

    typedef struct packed {
        logic [7:0] trial;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       startS [2];
    logic       gtS [2], ltS [2], eqS [2];
    logic [7:0] trialW [2], resultW [2];
    logic       busyW [2], doneW [2], exactW [2], errW [2];

    int         cfgTgt2 [2];
    int         cfgInj [2];
    bit         cfgGlitch [2];
    bit   [2:0] noise [2];

    bit         mActive [2];
    int         mC [2];
    plan_t      mPlan [2];
    bit   [7:0] hRes [2];
    bit         hEx [2], hErr [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sar_search8 #(.WIDTH(8), .SETTLE(SETTLE_A)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startS[0]),
        .cmp_gt(gtS[0]), .cmp_lt(ltS[0]), .cmp_eq(eqS[0]),
        .trial(trialW[0]), .busy(busyW[0]), .done(doneW[0]),
        .result(resultW[0]), .exact(exactW[0]), .err(errW[0])
    );

    sar_search8 #(.WIDTH(8), .SETTLE(SETTLE_B)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startS[1]),
        .cmp_gt(gtS[1]), .cmp_lt(ltS[1]), .cmp_eq(eqS[1]),
        .trial(trialW[1]), .busy(busyW[1]), .done(doneW[1]),
        .result(resultW[1]), .exact(exactW[1]), .err(errW[1])
    );

    function automatic int settleOf(input int d);
        return (d == 0) ? SETTLE_A : SETTLE_B;
    endfunction

    // Target is kept doubled so half-code thresholds (e.g. 0x3C.8) are representable.
    function automatic plan_t plan(input int tgt2, input int inj);
        plan_t p;
        logic [7:0] above, t;
        bit stop;
        int n;
        p = '0;
        above = '0;
        stop = 0;
        n = 0;
        for (int k = 7; k >= 0; k--) begin
            if (!stop) begin
                t = above | (8'd1 << k);
                p.tr[n] = t;
                n++;
                if (inj == n) begin
                    p.er = 1'b1;
                    stop = 1;
                end else if (2 * int'(t) == tgt2) begin
                    stop = 1;
                end else if (2 * int'(t) < tgt2) begin
                    above = t;
                end
            end
        end
        p.len = 4'(n);
        if (!p.er) begin
            for (int i = 0; i < n; i++) begin
                if (2 * int'(p.tr[i]) <= tgt2 && p.tr[i] > p.res) p.res = p.tr[i];
                if (2 * int'(p.tr[i]) == tgt2) p.ex = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic int doneCycle(input int d);
        return int'(mPlan[d].len) * (settleOf(d) + 1) + 1;
    endfunction

    function automatic logic [2:0] drive(input logic [7:0] t, input int tgt2, input int inj,
                                         input bit glitch, input bit [2:0] nz, input bit act,
                                         input int c, input int len, input int s);
        logic [2:0] base;
        bit samp;
        base = (2 * int'(t) > tgt2) ? 3'b100 : (2 * int'(t) < tgt2) ? 3'b010 : 3'b001;
        samp = act && c >= 1 && c <= len * (s + 1) && (c % (s + 1)) == 0;
        if (samp && inj == c / (s + 1)) return 3'b110;
        if (!samp && glitch) return nz;
        return base;
    endfunction

    assign {gtS[0], ltS[0], eqS[0]} = drive(trialW[0], cfgTgt2[0], cfgInj[0], cfgGlitch[0],
                                            noise[0], mActive[0], mC[0], int'(mPlan[0].len), SETTLE_A);
    assign {gtS[1], ltS[1], eqS[1]} = drive(trialW[1], cfgTgt2[1], cfgInj[1], cfgGlitch[1],
                                            noise[1], mActive[1], mC[1], int'(mPlan[1].len), SETTLE_B);

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) noise[d] <= 3'($urandom);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mActive[d] <= 1'b0;
                mC[d]      <= 0;
                mPlan[d]   <= '0;
                hRes[d]    <= '0;
                hEx[d]     <= 1'b0;
                hErr[d]    <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (startS[d] && (!mActive[d] || mC[d] == doneCycle(d))) begin
                    mPlan[d]   <= plan(cfgTgt2[d], cfgInj[d]);
                    mActive[d] <= 1'b1;
                    mC[d]      <= 1;
                    hRes[d]    <= '0;
                    hEx[d]     <= 1'b0;
                    hErr[d]    <= 1'b0;
                end else if (mActive[d]) begin
                    if (mC[d] == doneCycle(d)) begin
                        mActive[d] <= 1'b0;
                    end else begin
                        mC[d] <= mC[d] + 1;
                        if (mC[d] + 1 == doneCycle(d)) begin
                            hRes[d] <= mPlan[d].res;
                            hEx[d]  <= mPlan[d].ex;
                            hErr[d] <= mPlan[d].er;
                        end
                    end
                end
            end
        end
    end

    function automatic exp_t expectNow(input int d);
        exp_t e;
        int s;
        e = '0;
        s = settleOf(d);
        if (mActive[d] && mC[d] < doneCycle(d)) begin
            e.trial = mPlan[d].tr[(mC[d] - 1) / (s + 1)];
            e.busy  = 1'b1;
        end else if (mActive[d] && mC[d] == doneCycle(d)) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s dut%0d got %0h required %0h at %0t", name, d, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = expectNow(d);
            chk("trial",  d, 32'(trialW[d]),  32'(e.trial));
            chk("busy",   d, 32'(busyW[d]),   32'(e.busy));
            chk("done",   d, 32'(doneW[d]),   32'(e.done));
            chk("result", d, 32'(resultW[d]), 32'(hRes[d]));
            chk("exact",  d, 32'(exactW[d]),  32'(hEx[d]));
            chk("err",    d, 32'(errW[d]),    32'(hErr[d]));
        end
    end

    task automatic runSearch(input int d, input int tgt2, input int inj, input bit glitch,
                             input int pokeAt, input string name, input int expCyc,
                             input logic [7:0] expRes, input logic expEx, input logic expErr);
        int cyc;
        cfgTgt2[d]   = tgt2;
        cfgInj[d]    = inj;
        cfgGlitch[d] = glitch;
        @(negedge clk);
        startS[d] = 1'b1;
        @(negedge clk);
        startS[d] = 1'b0;
        cyc = 1;
        while (!doneW[d] && cyc < 100) begin
            @(negedge clk);
            cyc++;
            startS[d] = (cyc == pokeAt);
        end
        startS[d] = 1'b0;
        chk({name, ".doneSeen"}, d, 32'(doneW[d]), 32'd1);
        chk({name, ".cycle"},    d, 32'(cyc),        32'(expCyc));
        chk({name, ".result"},   d, 32'(resultW[d]), 32'(expRes));
        chk({name, ".exact"},    d, 32'(exactW[d]),  32'(expEx));
        chk({name, ".err"},      d, 32'(errW[d]),    32'(expErr));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] litA5 [8];
        int cyc;
        litA5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            startS[d] = 1'b0;
            cfgTgt2[d] = 0;
            cfgInj[d] = 0;
            cfgGlitch[d] = 0;
        end
        repeat (2) @(negedge clk);
        chk("reset.trial",  0, 32'(trialW[0]),  32'd0);
        chk("reset.busy",   0, 32'(busyW[0]),   32'd0);
        chk("reset.result", 0, 32'(resultW[0]), 32'd0);
        #2 rst_n = 1'b1;

        runSearch(0, 'h14A, 0, 0, 0, "tgtA5", 9, 8'hA5, 1'b1, 1'b0);
        chk("model.len", 0, 32'(mPlan[0].len), 32'd8);
        for (int i = 0; i < 8; i++) chk("model.trial", 0, 32'(mPlan[0].tr[i]), 32'(litA5[i]));

        runSearch(0, 'h100, 0, 0, 0, "tgt80",  2, 8'h80, 1'b1, 1'b0);
        runSearch(0, 'h1FE, 0, 0, 0, "tgtFF",  9, 8'hFF, 1'b1, 1'b0);
        runSearch(0, 'h079, 0, 0, 0, "thr3C8", 9, 8'h3C, 1'b0, 1'b0);
        runSearch(0, 'h000, 0, 0, 0, "tgt00",  9, 8'h00, 1'b0, 1'b0);
        runSearch(0, 'h0B4, 3, 0, 0, "badVerdict", 4, 8'h00, 1'b0, 1'b1);
        runSearch(0, 'h06E, 0, 0, 3, "startWhileBusy", 9, 8'h37, 1'b1, 1'b0);
        runSearch(1, 'h0B5, 0, 1, 0, "settle3", 33, 8'h5A, 1'b0, 1'b0);

        // Abort a search while bit 4 is on trial.
        cfgTgt2[0] = 'h0B4;
        cfgInj[0] = 0;
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.preTrial", 0, 32'(trialW[0]), 32'h50);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.trial",  0, 32'(trialW[0]),  32'd0);
        chk("abort.busy",   0, 32'(busyW[0]),   32'd0);
        chk("abort.done",   0, 32'(doneW[0]),   32'd0);
        chk("abort.result", 0, 32'(resultW[0]), 32'd0);
        chk("abort.exact",  0, 32'(exactW[0]),  32'd0);
        chk("abort.err",    0, 32'(errW[0]),    32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back: a start in the done cycle launches the next search at once.
        cfgTgt2[0] = 'h022;
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        cyc = 1;
        while (!doneW[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.first.cycle",  0, 32'(cyc),        32'd9);
        chk("b2b.first.result", 0, 32'(resultW[0]), 32'h11);
        cfgTgt2[0] = 'h044;
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        chk("b2b.busy",  0, 32'(busyW[0]),  32'd1);
        chk("b2b.trial", 0, 32'(trialW[0]), 32'h80);
        cyc = 1;
        while (!doneW[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.second.cycle",  0, 32'(cyc),        32'd8);
        chk("b2b.second.result", 0, 32'(resultW[0]), 32'h22);
        chk("b2b.second.exact",  0, 32'(exactW[0]),  32'd1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
